// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared constants, state encoding and row-major address
//               helpers for the 3x3 matrix-multiply MAC scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    // Matrix dimension and element count
    localparam int N          = 3;
    localparam int NN         = N * N;

    // Width of every memory index (covers 0..8)
    localparam int IDX_W      = 4;

    // Default datapath widths
    localparam int DEF_DATA_W = 8;
    localparam int DEF_OUT_W  = 8;
    localparam int DEF_ACC_W  = 2 * DEF_DATA_W + 2;

    // Scheduler state encoding
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_DRAIN = 3'd2;
    localparam state_t S_WRITE = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // Row-major index of element (r, c) in an N x N matrix
    function automatic logic [IDX_W-1:0] rm_addr(input logic [1:0] r,
                                                 input logic [1:0] c);
        return (IDX_W'(r) * IDX_W'(N)) + IDX_W'(c);
    endfunction

    // A operand index for output row r, inner term k
    function automatic logic [IDX_W-1:0] a_index(input logic [1:0] r,
                                                 input logic [1:0] k);
        return rm_addr(r, k);
    endfunction

    // B operand index for inner term k, output column c
    function automatic logic [IDX_W-1:0] b_index(input logic [1:0] k,
                                                 input logic [1:0] c);
        return rm_addr(k, c);
    endfunction

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mac
// Description : Single registered multiply-accumulate unit. When enabled it
//               either loads the unsigned product (first term of a dot
//               product) or adds it to the running accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clear_first,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    r_acc;

    // Full-precision unsigned product, zero-extended to the accumulator width
    assign w_prod     = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign w_prod_ext = ACC_W'(w_prod);

    // Accumulator: load on the first term of an element, add on later terms
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clear_first) begin
                r_acc <= w_prod_ext;
            end else begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    assign o_acc = r_acc;

endmodule : matmul_mac
`default_nettype wire

// File: rtl/matmul_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mac_scheduler
// Description : Computes C = A x B for 3x3 matrices held in synchronous-read
//               memories using one shared MAC issued 27 times. Each output
//               element takes five cycles: three FETCH, one DRAIN, one WRITE.
//               Optional build macro MATMUL_SAT_EN selects saturating C
//               results; without it results are truncated modulo 2^OUT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mac_scheduler
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int ACC_W  = 2 * DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [IDX_W-1:0]  a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic [IDX_W-1:0]  b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic [IDX_W-1:0]  c_addr,
    output logic [OUT_W-1:0]  c_wdata,
    output logic              c_we,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    // Largest value representable in a C element, at accumulator width
    localparam logic [ACC_W-1:0] c_OUT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic [1:0]       c_K_LAST  = 2'(N - 1);
    localparam logic [1:0]       c_C_LAST  = 2'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_row;
    logic [1:0]       r_col;
    logic [1:0]       r_k;
    logic [IDX_W-1:0] r_a_hold;
    logic [IDX_W-1:0] r_b_hold;
    logic             r_mac_en;
    logic             r_mac_first;
    logic             r_ovf;

    logic             w_in_fetch;
    logic             w_in_write;
    logic             w_abort_act;
    logic             w_last_elem;
    logic             w_acc_over;
    logic [IDX_W-1:0] w_a_idx;
    logic [IDX_W-1:0] w_b_idx;
    logic [IDX_W-1:0] w_c_idx;
    logic [ACC_W-1:0] w_acc;
    logic [OUT_W-1:0] w_wdata;

    assign w_in_fetch  = (r_state == S_FETCH);
    assign w_in_write  = (r_state == S_WRITE);
    assign w_abort_act = abort && (r_state != S_IDLE);

    assign w_a_idx     = a_index(r_row, r_k);
    assign w_b_idx     = b_index(r_k, r_col);
    assign w_c_idx     = rm_addr(r_row, r_col);
    assign w_last_elem = (w_c_idx == IDX_W'(NN - 1));
    assign w_acc_over  = (w_acc > c_OUT_MAX);

    // Next-state logic; an abort from any busy state returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (r_k == c_K_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_last_elem ? S_DONE : S_FETCH;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort_act) begin
            w_state_nxt = S_IDLE;
        end
    end

    // State register, element/term counters, address hold and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_a_hold    <= '0;
            r_b_hold    <= '0;
            r_mac_en    <= 1'b0;
            r_mac_first <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // The memory answers one cycle after FETCH, so the MAC strobe
            // and its first-term flag trail the FETCH cycle by one.
            r_mac_en    <= w_in_fetch && !w_abort_act;
            r_mac_first <= (r_k == 2'd0);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_k   <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_a_hold <= w_a_idx;
                    r_b_hold <= w_b_idx;
                    if (r_k != c_K_LAST) begin
                        r_k <= r_k + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!w_abort_act) begin
                        if (w_acc_over) begin
                            r_ovf <= 1'b1;
                        end
                        if (!w_last_elem) begin
                            r_k <= '0;
                            if (r_col == c_C_LAST) begin
                                r_col <= '0;
                                r_row <= r_row + 2'd1;
                            end else begin
                                r_col <= r_col + 2'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk           (clk),
        .rst           (rst),
        .i_en          (r_mac_en),
        .i_clear_first (r_mac_first),
        .i_a           (a_rdata),
        .i_b           (b_rdata),
        .o_acc         (w_acc)
    );

`ifdef MATMUL_SAT_EN
    // Saturate results that do not fit in a C element
    assign w_wdata = w_acc_over ? {OUT_W{1'b1}} : w_acc[OUT_W-1:0];
`else
    // Keep the low bits, matching the legacy 8-bit result path
    assign w_wdata = w_acc[OUT_W-1:0];
`endif

    // Addresses track the counters in FETCH and hold their last value elsewhere
    assign a_addr  = w_in_fetch ? w_a_idx : r_a_hold;
    assign b_addr  = w_in_fetch ? w_b_idx : r_b_hold;

    assign c_addr  = w_c_idx;
    assign c_wdata = w_wdata;
    assign c_we    = w_in_write && !abort;
    assign done    = (r_state == S_DONE) && !abort;
    assign busy    = (r_state != S_IDLE);
    assign ovf     = r_ovf;

endmodule : matmul_mac_scheduler
`default_nettype wire

// File: tb/tb_matmul_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_mac_scheduler
// Description : Scoreboard bench for matmul_mac_scheduler. Expected C writes
//               come from a plain-arithmetic matrix product; a monitor pops
//               them whenever c_we is seen. Honours MATMUL_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_mac_scheduler;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 8;
    localparam int ACC_W  = 2 * DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [3:0]        a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic [3:0]        b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic [3:0]        c_addr;
    logic [OUT_W-1:0]  c_wdata;
    logic              c_we;
    logic              busy;
    logic              done;
    logic              ovf;

    logic [DATA_W-1:0] a_mem [9];
    logic [DATA_W-1:0] b_mem [9];

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    matmul_mac_scheduler #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .a_addr  (a_addr),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_rdata (b_rdata),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_we    (c_we),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read A/B memories
    always @(posedge clk) begin
        a_rdata <= (a_addr < 4'd9) ? a_mem[a_addr] : '0;
        b_rdata <= (b_addr < 4'd9) ? b_mem[b_addr] : '0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every C write must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t w;
        if (c_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got write addr %0d data %0d expected none",
                         c_addr, c_wdata);
            end else begin
                w = sb_q.pop_front();
                check("c_addr", int'(c_addr), w.addr);
                check("c_wdata", int'(c_wdata), w.data);
            end
        end
    end

    // Reference C = A x B; queue writes landing no later than last_cyc
    task automatic push_expect(input int last_cyc, output bit ovf_exp);
        int s;
        wr_t w;
        ovf_exp = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += int'(a_mem[r*3+k]) * int'(b_mem[k*3+c]);
                end
                w.addr = r * 3 + c;
`ifdef MATMUL_SAT_EN
                w.data = (s > 255) ? 255 : s;
`else
                w.data = s % 256;
`endif
                if (s > 255) ovf_exp = 1'b1;
                if (5 + 5 * w.addr <= last_cyc) sb_q.push_back(w);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    int'(busy),    0);
        check({tag, "_done"},    int'(done),    0);
        check({tag, "_c_we"},    int'(c_we),    0);
        check({tag, "_ovf"},     int'(ovf),     0);
        check({tag, "_a_addr"},  int'(a_addr),  0);
        check({tag, "_b_addr"},  int'(b_addr),  0);
        check({tag, "_c_addr"},  int'(c_addr),  0);
        check({tag, "_c_wdata"}, int'(c_wdata), 0);
    endtask

    // One run: start at edge 0, optional abort/reset/busy-start/held-start
    task automatic run(input int abort_cyc, input int rst_cyc,
                       input int pulse_cyc, input bit hold);
        bit ovf_exp;
        int lim;
        int last;
        bit quiet;
        quiet = (abort_cyc == 0) && (rst_cyc == 0);
        lim   = (abort_cyc > 0) ? abort_cyc - 1 : ((rst_cyc > 0) ? rst_cyc : 45);
        last  = (rst_cyc > 0) ? rst_cyc + 1 : (hold ? 48 : 47);
        push_expect(lim, ovf_exp);
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                check_reset_outputs("mid_rst");
            end else if (cyc <= 47) begin
                check("busy", int'(busy),
                      (abort_cyc > 0) ? int'(cyc <= abort_cyc)
                                      : ((rst_cyc > 0) ? int'(cyc <= rst_cyc) : int'(cyc <= 46)));
                check("done", int'(done), int'(quiet && cyc == 46));
                check("c_we", int'(c_we), int'((cyc % 5 == 0) && cyc <= lim));
                if (quiet && cyc == 46) check("ovf", int'(ovf), int'(ovf_exp));
            end
            if (hold && cyc == 48) begin
                check("restart_busy", int'(busy), 1);
                check("restart_ovf_clear", int'(ovf), 0);
            end
            start = (cyc == pulse_cyc) || (hold && cyc >= 40 && cyc <= 47);
            abort = (cyc == abort_cyc) || (hold && cyc == 48);
            rst   = (cyc == rst_cyc);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        check("queue_empty", sb_q.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // abort while idle changes nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);

        // identity x 1..9
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
            b_mem[i] = DATA_W'(i + 1);
        end
        run(0, 0, 0, 1'b0);

        // start pulsed while busy is ignored
        run(0, 0, 20, 1'b0);

        // full scale, start held through DONE into a new run
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = 8'hFF;
            b_mem[i] = 8'hFF;
        end
        run(0, 0, 0, 1'b1);

        // abort mid-element 4
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = DATA_W'($urandom_range(0, 255));
            b_mem[i] = DATA_W'($urandom_range(0, 255));
        end
        run(23, 0, 0, 1'b0);
        run(0, 0, 0, 1'b0);

        // reset mid-run
        run(0, 30, 0, 1'b0);

        // random matrices, alternating full range and small values
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 9; i++) begin
                a_mem[i] = DATA_W'((n % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9));
                b_mem[i] = DATA_W'((n % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9));
            end
            run(0, 0, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_matmul_mac_scheduler
`default_nettype wire

// File: doc/matmul_mac_scheduler.md
# matmul_mac_scheduler

- Sequencer that computes a 3x3 by 3x3 matrix product C = A x B using one shared multiply-accumulate unit.
- A and B live in external 9-entry synchronous-read memories, loaded by the switch/button capture logic. Results are written into the C memory, which the LED display path reads.
- Sits between the input-capture FSM and the display FSM. It replaces the nine parallel three-term dot products with one MAC issued 27 times, driven by a start/busy/done handshake.

## Interface
- DATA_W, 8, width of A/B elements
- OUT_W, 8, width of written C elements
- ACC_W, 2*DATA_W+2, accumulator width (holds 3 full-scale products without loss)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a multiply run; sampled only in IDLE
- abort  in  1  cancel the run in progress; synchronous
- a_addr  out  4  A read address, row-major 0..8
- a_rdata  in  DATA_W  A read data, valid one cycle after a_addr
- b_addr  out  4  B read address, row-major 0..8
- b_rdata  in  DATA_W  B read data, valid one cycle after b_addr
- c_addr  out  4  C write address
- c_wdata  out  OUT_W  C write data
- c_we  out  1  C write strobe, one cycle per element
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the ninth element is written
- ovf  out  1  sticky: some element this run exceeded 2^OUT_W-1; cleared when start is accepted

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- Counters: row (0..2), col (0..2), k (0..2). Element order is row-major, with e = row*3+col.
- **IDLE:** when start=1, clear ovf, row, col and k, then go to FETCH. Otherwise stay in IDLE.
- **FETCH:** drive a_addr = row*3+k and b_addr = k*3+col.
  - If k=2, go to DRAIN. Otherwise k <= k+1.
- **MAC:** the product a_rdata*b_rdata (2*DATA_W bits, unsigned) is accepted one cycle after each FETCH.
  - First term of an element (k=0 data): acc <= product.
  - Later terms: acc <= acc + product.
- **DRAIN:** accepts the k=2 term, then goes to WRITE.
- **WRITE:**
  - c_we=1 and c_addr = row*3+col.
  - c_wdata is the OUT_W-bit result described under Configuration.
  - If acc > 2^OUT_W-1, set ovf.
  - If e=8, go to DONE. Otherwise advance col, wrapping to 0 and incrementing row, clear k, and go to FETCH.
- **DONE:** done=1 for one cycle, then go to IDLE.
  - start is ignored in DONE; it is honoured next cycle in IDLE.
- **abort:** when abort=1 in any non-IDLE state, next state is IDLE.
  - c_we and done are forced 0 in that cycle.
  - C is left partially written; ovf is left as is.
- start while busy: ignored. abort in IDLE: no effect.
- rst has priority over everything, including start and abort in the same cycle.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, c_we=0, ovf=0, a_addr=0, b_addr=0, c_addr=0, c_wdata=0.
  - Internal: state=IDLE, acc=0, counters=0.
- Cycle numbering: start sampled at edge 0 means cycle 1 is the first FETCH.
- Element e occupies cycles 1+5e .. 5+5e: three FETCH, one DRAIN, one WRITE.
- WRITE for element e is in cycle 5+5e. The last write is cycle 45.
- done is high in cycle 46. IDLE is reached in cycle 47.
- Total latency is 46 cycles from start to done.
- busy is high in cycles 1..46.
- Address outputs hold their last value outside FETCH. They are don't-care for the memories.

## Configuration
- MATMUL_SAT_EN defined: c_wdata = min(acc, 2^OUT_W-1), i.e. saturating.
- MATMUL_SAT_EN undefined: c_wdata = acc[OUT_W-1:0], i.e. modulo truncation, the same as the existing 8-bit result path.
- ovf behaves identically in both builds.

## Structure
- matmul_pkg holds:
  - the state enum
  - N=3 and N*N=9
  - the index width (4)
  - the default widths
  - row-major address helper functions
- One sub-module: matmul_mac.
  - Registered accumulator with clear_first and en inputs.
  - ACC_W output.
  - Instantiated once by the scheduler.

## Test plan
- **Identity:** A=I, B=1..9, start → C=1..9; done in cycle 46; nine c_we pulses at cycles 5,10,...,45; ovf=0.
- **Full scale:** A and B all 0xFF (each element 195075) → C all 0x03 without MATMUL_SAT_EN, all 0xFF with it; ovf=1 in both builds.
- **Start while busy:** start pulsed at cycle 20 → ignored; run completes unchanged at cycle 46. start held through DONE → new run begins after one IDLE cycle, and ovf is cleared then.
- **Abort:** abort at cycle 23 → IDLE at cycle 24; C[0..3] written, no further c_we, no done pulse; a subsequent start runs a full 46 cycles.
- **Reset mid-run:** rst at cycle 30 → all outputs at reset values the next cycle; ovf=0; busy=0.
- **Random:** random A/B, compare C against a reference model for 100 runs in both builds.
